mem_block_copier: RTL and testbench
===================================

MEM_BLOCK_COPIER -- requirements
Module: mem_block_copier

Interface
REQ-001: Parameter STEP, default 2, byte-address increment per 16-bit word (memory is byte-addressed, big-endian, 2 bytes per word).
REQ-002: clk  input  1  single clock; all state updates on posedge clk.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request a transfer; sampled only in IDLE.
REQ-005: fillMode  input  1  0 = copy src->dst, 1 = write fillValue to dst; sampled with start.
REQ-006: abort  input  1  cancel an in-progress transfer.
REQ-007: srcAddr  input  16  source byte address; sampled with start.
REQ-008: dstAddr  input  16  destination byte address; sampled with start.
REQ-009: wordCount  input  16  number of 16-bit words to move; sampled with start.
REQ-010: fillValue  input  16  fill word; sampled with start.
REQ-011: memAddressA  output  16  memory read-port address.
REQ-012: memDataOutA  input  16  memory read data, combinational from memAddressA.
REQ-013: memAddressB  output  16  memory write-port address.
REQ-014: memDataInB  output  16  memory write data.
REQ-015: memWriteEnableB  output  1  memory write strobe; memory commits on negedge clk of the same cycle.
REQ-016: memWriteEnableA  output  1  tied to 0.
REQ-017: busy  output  1  high in READ, WRITE, and DONE states.
REQ-018: done  output  1  one-cycle pulse at end of transfer or abort.
REQ-019: wordsLeft  output  16  words not yet written.

Function
REQ-020: The FSM shall have states IDLE, READ, WRITE, and DONE; all outputs shall be driven from registers or decoded from state only.
REQ-021: IDLE with start=1 shall latch srcPtr, dstPtr, wordsLeft, mode, and fill data; next state: DONE if wordCount=0, else WRITE if fillMode=1, else READ.
REQ-022: In READ, memAddressA shall equal srcPtr, and memDataOutA shall be captured into dataReg at the closing posedge; next state: WRITE.
REQ-023: In WRITE, memAddressB shall equal dstPtr, memDataInB shall equal dataReg (or fillValue in fill mode), and memWriteEnableB shall be 1.
REQ-024: At the closing posedge of WRITE, dstPtr+=STEP, srcPtr+=STEP (copy mode only), and wordsLeft-=1; next state: DONE if wordsLeft was 1, else READ (copy) or WRITE (fill).
REQ-025: Copy throughput shall be 2 cycles/word; fill throughput shall be 1 cycle/word; start-to-first-write latency shall be 2 cycles (copy) or 1 cycle (fill).
REQ-026: DONE shall assert done=1 for exactly one cycle, then return to IDLE; busy shall drop in the cycle after DONE.
REQ-027: Pointer arithmetic shall be modulo 2^16; address 0xFFFE+STEP shall wrap to 0x0000 without error.
REQ-028: memWriteEnableB shall be 0 in all states other than WRITE; memAddressA, memAddressB, and memDataInB shall hold their last values outside READ/WRITE.
REQ-029: Copy shall be strictly ascending, word by word; for overlapping regions, each read shall observe all earlier writes of the same transfer.
REQ-030: abort=1 in READ or WRITE shall force DONE at the next posedge, and any write already strobed in the current cycle shall complete; wordsLeft shall hold the remaining count.
REQ-031: abort in IDLE or DONE shall be ignored, and start while busy shall be ignored; if start and abort are both high in IDLE, start shall win.
REQ-032: Odd srcAddr or dstAddr shall be accepted unchanged, giving unaligned byte-pair access.

Reset
REQ-033: rst=1 shall immediately force state IDLE and set busy=0, done=0, memWriteEnableB=0, wordsLeft=0, memAddressA=0, memAddressB=0, memDataInB=0, dataReg=0, and all pointers to 0.
REQ-034: rst asserted mid-transfer shall abandon the transfer with no done pulse, and no write strobe shall occur after rst rises.
REQ-035: After rst deasserts, the block shall accept start on the first posedge.

Verification
REQ-036: Copy: mem[0x0100..0x0105]=11 22 33 44 55 66, start src=0x0100 dst=0x0200 count=3 -> mem[0x0200..0x0205]=11 22 33 44 55 66, three write strobes, done pulse 7 cycles after start.
REQ-037: Fill: fillValue=0xBEEF, dst=0x0010, count=4 -> mem[0x0010..0x0017]=BE EF repeated, 4 consecutive write cycles, done in cycle 5.
REQ-038: Wrap: dst=0xFFFE, fill 0x1234, count=2 -> mem[0xFFFE]=12, mem[0xFFFF]=34, mem[0x0000]=12, mem[0x0001]=34.
REQ-039: Zero count: count=0 -> no write strobes, done 1 cycle after start, busy high for 1 cycle.
REQ-040: Abort: copy count=10, assert abort during the 3rd WRITE -> exactly 3 words written, wordsLeft=7, single done pulse, then IDLE.
REQ-041: Reset mid-transfer: fill count=8, rst pulse after the 2nd write -> exactly 2 words written, all outputs 0, no done pulse, and a new start is accepted immediately after rst deasserts.

Source files
------------

// File: rtl/mem_block_copier.sv
// Block copy / fill engine for a byte-addressed, big-endian, one-read/one-write memory.
// Copy alternates READ/WRITE (2 cycles/word); fill streams WRITE (1 cycle/word).
module mem_block_copier #(
  parameter int unsigned STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fillMode,
  input  logic        abort,
  input  logic [15:0] srcAddr,
  input  logic [15:0] dstAddr,
  input  logic [15:0] wordCount,
  input  logic [15:0] fillValue,
  output logic [15:0] memAddressA,
  input  logic [15:0] memDataOutA,
  output logic [15:0] memAddressB,
  output logic [15:0] memDataInB,
  output logic        memWriteEnableB,
  output logic        memWriteEnableA,
  output logic        busy,
  output logic        done,
  output logic [15:0] wordsLeft,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [15:0] STEP16 = 16'(STEP);

  state_t      state_q;
  logic [15:0] src_ptr_q;
  logic [15:0] dst_ptr_q;
  logic [15:0] words_left_q;
  logic [15:0] fill_q;
  logic [15:0] data_q;
  logic [15:0] addr_a_q;
  logic [15:0] addr_b_q;
  logic [15:0] wdata_q;
  logic        mode_q;
  logic        we_q;
  logic        busy_q;
  logic        done_q;

  // Request handshake: start is accepted only on a posedge where busy=0 (IDLE);
  // each accepted request ends in exactly one done pulse unless rst intervenes.
  // Memory-port registers are loaded on entry to READ/WRITE so they hold elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      words_left_q <= '0;
      fill_q       <= '0;
      data_q       <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      wdata_q      <= '0;
      mode_q       <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            src_ptr_q    <= srcAddr;
            dst_ptr_q    <= dstAddr;
            words_left_q <= wordCount;
            mode_q       <= fillMode;
            fill_q       <= fillValue;
            busy_q       <= 1'b1;
            if (wordCount == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (fillMode) begin
              state_q  <= WRITE;
              we_q     <= 1'b1;
              addr_b_q <= dstAddr;
              wdata_q  <= fillValue;
            end else begin
              state_q  <= READ;
              addr_a_q <= srcAddr;
            end
          end
        end
        READ: begin
          if (abort) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            data_q   <= memDataOutA;
            wdata_q  <= memDataOutA;
            addr_b_q <= dst_ptr_q;
            we_q     <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          // The strobed write always completes, so the word counts even on abort.
          dst_ptr_q    <= dst_ptr_q + STEP16;
          words_left_q <= words_left_q - 16'd1;
          if (!mode_q) src_ptr_q <= src_ptr_q + STEP16;
          if (abort || words_left_q == 16'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (mode_q) begin
            we_q     <= 1'b1;
            addr_b_q <= dst_ptr_q + STEP16;
            wdata_q  <= fill_q;
          end else begin
            addr_a_q <= src_ptr_q + STEP16;
            state_q  <= READ;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memAddressA     = addr_a_q;
  assign memAddressB     = addr_b_q;
  assign memDataInB      = wdata_q;
  assign memWriteEnableB = we_q;
  assign memWriteEnableA = 1'b0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign wordsLeft       = words_left_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: byte memory model, per-cycle schedule reference,
// directed corner transfers and randomized transfers.
module tb_mem_block_copier;
  localparam int STEP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fillMode = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] srcAddr = '0;
  logic [15:0] dstAddr = '0;
  logic [15:0] wordCount = '0;
  logic [15:0] fillValue = '0;
  logic [15:0] memAddressA;
  logic [15:0] memDataOutA;
  logic [15:0] memAddressB;
  logic [15:0] memDataInB;
  logic        memWriteEnableB;
  logic        memWriteEnableA;
  logic        busy;
  logic        done;
  logic [15:0] wordsLeft;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_block_copier #(.STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .fillMode(fillMode), .abort(abort),
    .srcAddr(srcAddr), .dstAddr(dstAddr), .wordCount(wordCount), .fillValue(fillValue),
    .memAddressA(memAddressA), .memDataOutA(memDataOutA), .memAddressB(memAddressB),
    .memDataInB(memDataInB), .memWriteEnableB(memWriteEnableB),
    .memWriteEnableA(memWriteEnableA), .busy(busy), .done(done),
    .wordsLeft(wordsLeft), .dbg_state_o(dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        mem_init = 1'b0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_byte = '0;
  logic [15:0] addr_a1;
  logic [15:0] addr_b1;

  assign addr_a1     = memAddressA + 16'd1;
  assign addr_b1     = memAddressB + 16'd1;
  assign memDataOutA = {mem[memAddressA], mem[addr_a1]};

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_byte;
    end
    if (memWriteEnableB) begin
      mem[memAddressB] <= memDataInB[15:8];
      mem[addr_b1]     <= memDataInB[7:0];
    end
  end

  // ---------------- expected per-cycle outputs ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        we;
    logic [15:0] wl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t idle_e = '0;
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   done_cyc = 0;

  task automatic check_outputs(input string nm, input exp_t e);
    vectors++;
    if (busy !== e.busy || done !== e.done || memWriteEnableB !== e.we ||
        wordsLeft !== e.wl || memAddressA !== e.a || memAddressB !== e.b ||
        memDataInB !== e.d || memWriteEnableA !== 1'b0) begin
      errors++;
      $display("FAIL %s cyc=%0d got busy=%b done=%b weB=%b weA=%b wl=%h a=%h b=%h d=%h, want busy=%b done=%b weB=%b weA=0 wl=%h a=%h b=%h d=%h",
               nm, cyc, busy, done, memWriteEnableB, memWriteEnableA, wordsLeft, memAddressA,
               memAddressB, memDataInB, e.busy, e.done, e.we, e.wl, e.a, e.b, e.d);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Single compare process: every cycle, outputs against the schedule or idle holds.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst) begin
      idle_e = '0;
      check_outputs("reset_state", '0);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_outputs("transfer", e);
      idle_e      = e;
      idle_e.busy = 1'b0;
      idle_e.done = 1'b0;
      idle_e.we   = 1'b0;
    end else begin
      check_outputs("idle_hold", idle_e);
    end
    if (memWriteEnableB) we_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] h_a = '0;
  logic [15:0] h_b = '0;
  logic [15:0] h_d = '0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {ref_mem[a], ref_mem[a1]};
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  // Expected transfer as a list of cycles; ref_mem takes each committed write in order,
  // so later reads of an overlapping copy see earlier writes.
  task automatic build(input logic fm, input logic [15:0] src, dst, n, fv,
                       input int abort_rd, abort_wr, rst_wr);
    exp_t e;
    logic [15:0] off, b1, d;
    e = '0;
    e.busy = 1'b1; e.a = h_a; e.b = h_b; e.d = h_d;
    if (n == 16'd0) begin
      e.done = 1'b1;
      exp_q.push_back(e);
    end
    for (int k = 0; k < int'(n); k++) begin
      off  = 16'(STEP * k);
      e.wl = 16'(int'(n) - k);
      e.we = 1'b0;
      if (!fm) begin
        e.a = src + off;
        exp_q.push_back(e);
        if (abort_rd == k + 1) begin
          e.done = 1'b1;
          exp_q.push_back(e);
          break;
        end
        d = ref_rd(e.a);
      end else begin
        d = fv;
      end
      e.we = 1'b1; e.b = dst + off; e.d = d;
      exp_q.push_back(e);
      if (rst_wr == k) break;
      b1 = e.b + 16'd1;
      ref_mem[e.b] = d[15:8];
      ref_mem[b1]  = d[7:0];
      if (abort_wr == k + 1 || k == int'(n) - 1) begin
        e.we = 1'b0; e.done = 1'b1; e.wl = 16'(int'(n) - k - 1);
        exp_q.push_back(e);
        break;
      end
    end
    h_a = e.a; h_b = e.b; h_d = e.d;
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  int t0, we0, dn0, busy0;

  task automatic run_transfer(input logic fm, input logic [15:0] src, dst, n, fv,
                              input int abort_rd, abort_wr, input logic abort_first);
    int total, abort_cyc;
    t0 = cyc; we0 = we_cnt; dn0 = done_cnt; busy0 = busy_cnt;
    build(fm, src, dst, n, fv, abort_rd, abort_wr, -1);
    total = exp_q.size();
    abort_cyc = 0;
    if (abort_wr > 0) abort_cyc = fm ? abort_wr : 2 * abort_wr;
    else if (abort_rd > 0) abort_cyc = 2 * abort_rd - 1;
    fillMode = fm; srcAddr = src; dstAddr = dst; wordCount = n; fillValue = fv;
    start = 1'b1; abort = abort_first;
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      fillMode  = 1'($urandom_range(0, 1));
      srcAddr   = 16'($urandom);
      dstAddr   = 16'($urandom);
      wordCount = 16'($urandom_range(0, 9));
      fillValue = 16'($urandom);
      if (c == abort_cyc) abort = 1'b1;
      else if (c == total) abort = 1'($urandom_range(0, 1));
      else abort = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    ref_mem[a] = v;
    @(posedge clk);
    pre_we = 1'b1; pre_addr = a; pre_byte = v;
    @(posedge clk);
    pre_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem_check(input string nm);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 65536; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s %0d bytes differ, first at %h got=%h want=%h",
               nm, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        fm, af;
    logic [15:0] src, dst, n, fv;
    int          ar, aw, sel;

    // clock/reset block, memory seeded with a known pattern during reset
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 11);
    @(posedge clk);
    mem_init = 1'b1;
    @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // copy of three words
    poke(16'h0100, 8'h11); poke(16'h0101, 8'h22); poke(16'h0102, 8'h33);
    poke(16'h0103, 8'h44); poke(16'h0104, 8'h55); poke(16'h0105, 8'h66);
    run_transfer(1'b0, 16'h0100, 16'h0200, 16'd3, 16'h0000, 0, 0, 1'b0);
    chk16("copy_w0", mem_word(16'h0200), 16'h1122);
    chk16("copy_w1", mem_word(16'h0202), 16'h3344);
    chk16("copy_w2", mem_word(16'h0204), 16'h5566);
    chk16("copy_strobes", 16'(we_cnt - we0), 16'd3);
    chk16("copy_done_latency", 16'(done_cyc - t0), 16'd7);
    mem_check("copy_mem");

    // fill of four words
    run_transfer(1'b1, 16'h0000, 16'h0010, 16'd4, 16'hBEEF, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) chk16("fill_word", mem_word(16'(16'h0010 + 2 * k)), 16'hBEEF);
    chk16("fill_strobes", 16'(we_cnt - we0), 16'd4);
    chk16("fill_done_latency", 16'(done_cyc - t0), 16'd5);

    // address wrap
    run_transfer(1'b1, 16'h0000, 16'hFFFE, 16'd2, 16'h1234, 0, 0, 1'b0);
    chk16("wrap_fffe", {8'h00, mem[16'hFFFE]}, 16'h0012);
    chk16("wrap_ffff", {8'h00, mem[16'hFFFF]}, 16'h0034);
    chk16("wrap_0000", {8'h00, mem[16'h0000]}, 16'h0012);
    chk16("wrap_0001", {8'h00, mem[16'h0001]}, 16'h0034);

    // zero count
    run_transfer(1'b0, 16'h0300, 16'h0400, 16'd0, 16'h0000, 0, 0, 1'b0);
    chk16("zero_strobes", 16'(we_cnt - we0), 16'd0);
    chk16("zero_done_latency", 16'(done_cyc - t0), 16'd1);
    chk16("zero_busy_cycles", 16'(busy_cnt - busy0), 16'd1);

    // abort during the third write of a copy
    run_transfer(1'b0, 16'h0700, 16'h0800, 16'd10, 16'h0000, 0, 3, 1'b0);
    chk16("abort_strobes", 16'(we_cnt - we0), 16'd3);
    chk16("abort_words_left", wordsLeft, 16'd7);
    chk16("abort_done_pulses", 16'(done_cnt - dn0), 16'd1);

    // abort during the second read of a copy
    run_transfer(1'b0, 16'h0900, 16'h0A00, 16'd5, 16'h0000, 2, 0, 1'b0);
    chk16("abort_rd_strobes", 16'(we_cnt - we0), 16'd1);
    chk16("abort_rd_words_left", wordsLeft, 16'd4);

    // start and abort together in IDLE: start wins
    run_transfer(1'b1, 16'h0000, 16'h0B00, 16'd2, 16'h5A5A, 0, 0, 1'b1);
    chk16("start_beats_abort", 16'(we_cnt - we0), 16'd2);

    // overlapping ascending copy propagates the first word
    run_transfer(1'b0, 16'h0C00, 16'h0C02, 16'd4, 16'h0000, 0, 0, 1'b0);
    mem_check("overlap_mem");

    // reset after the second write of a fill
    dn0 = done_cnt; we0 = we_cnt;
    build(1'b1, 16'h0000, 16'h0600, 16'd8, 16'hA5C3, 0, 0, 2);
    fillMode = 1'b1; dstAddr = 16'h0600; wordCount = 16'd8; fillValue = 16'hA5C3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("reset_async", '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    h_a = '0; h_b = '0; h_d = '0;
    chk16("reset_no_done", 16'(done_cnt - dn0), 16'd0);
    chk16("reset_strobes", 16'(we_cnt - we0), 16'd3);
    run_transfer(1'b1, 16'h0000, 16'h0D00, 16'd1, 16'h0F0F, 0, 0, 1'b0);
    chk16("reset_word0", mem_word(16'h0600), 16'hA5C3);
    chk16("reset_word1", mem_word(16'h0602), 16'hA5C3);
    chk16("after_reset_fill", mem_word(16'h0D00), 16'h0F0F);
    mem_check("reset_mem");

    // randomized transfers
    for (int it = 0; it < 24; it++) begin
      fm  = 1'($urandom_range(0, 1));
      src = 16'($urandom);
      dst = ($urandom_range(0, 1) == 1) ? 16'(src + 16'($urandom_range(0, 6))) : 16'($urandom);
      n   = 16'($urandom_range(0, 6));
      fv  = 16'($urandom);
      af  = 1'($urandom_range(0, 1));
      ar  = 0; aw = 0;
      sel = int'($urandom_range(0, 7));
      if (n != 0 && sel < 2) aw = int'($urandom_range(1, int'(n)));
      else if (n != 0 && !fm && sel == 2) ar = int'($urandom_range(1, int'(n)));
      run_transfer(fm, src, dst, n, fv, ar, aw, af);
      mem_check("random_mem");
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
